// File: rtl/register_file_sb.sv
// ---------------------------------------------------------------------------
// register_file_sb
//   Second-generation Galetron register file: one write port, two
//   asynchronous read ports, a sequential clear sweep, per-register busy
//   (scoreboard) bits and an optional write-to-read bypass.
//
//   Optional feature macro: REGISTER_FILE_BYPASS_EN
//     defined   -> a same-cycle write to a read index is forwarded to that
//                  read port (writeData, busy 0)
//     undefined -> reads show stored contents only
//
// Parameters
//   DATA_W    register width in bits
//   DEPTH     number of registers (power of 2, >= 2)
//   ZERO_REG  hardwired-zero index: reads 0, writes ignored, never busy
//
// Ports
//   clock           single clock, all state updates on posedge
//   reset           asynchronous active-low reset
//   clear           synchronous request to restart the clear sweep
//   writeRegister   write enable
//   writeAddress    write index
//   writeData       write value
//   readAddress1    port A read index
//   readAddress2    port B read index
//   reserveValid    mark reserveAddress busy
//   reserveAddress  index to mark busy
//   dataA / dataB   read data of port A / port B
//   busyA / busyB   busy bit of readAddress1 / readAddress2
//   ready           sweep complete, file usable
//
// State table
//   state   | meaning
//   S_CLEAR | sweep writing 0 to entry[counter]; ports ignored, outputs 0
//   S_READY | normal operation
// ---------------------------------------------------------------------------
module register_file_sb #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 31,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              writeRegister,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readAddress1,
  input  logic [ADDR_W-1:0] readAddress2,
  input  logic              reserveValid,
  input  logic [ADDR_W-1:0] reserveAddress,
  output logic [DATA_W-1:0] dataA,
  output logic [DATA_W-1:0] dataB,
  output logic              busyA,
  output logic              busyB,
  output logic              ready
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   counter_q, counter_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                sweep_we;
  logic                wr_fire;
  logic                rsv_fire;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_CLEAR;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    unique case (state_q)
      S_CLEAR: begin
        counter_d = counter_q + 1'b1;
        if (counter_q == LAST_IDX) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (clear) begin
          state_d   = S_CLEAR;
          counter_d = '0;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        counter_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs / enables
  // clear in READY wins over a same-cycle write or reserve.
  // -------------------------------------------------------------------------
  always_comb begin
    ready    = 1'b0;
    sweep_we = 1'b0;
    wr_fire  = 1'b0;
    rsv_fire = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        sweep_we = 1'b1;
      end
      S_READY: begin
        ready    = 1'b1;
        wr_fire  = !clear && writeRegister && (writeAddress != ZERO_IDX);
        rsv_fire = !clear && reserveValid && (reserveAddress != ZERO_IDX);
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Storage: no reset on the array itself, the sweep zeroes it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (sweep_we) begin
      mem[counter_q] <= '0;
    end else if (wr_fire) begin
      mem[writeAddress] <= writeData;
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard. Reserve is applied after the write-side clear so a new
  // producer supersedes one retiring on the same edge.
  // -------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (state_q != S_READY || clear) begin
      busy_d = '0;
    end else begin
      if (wr_fire) begin
        busy_d[writeAddress] = 1'b0;
      end
      if (rsv_fire) begin
        busy_d[reserveAddress] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports (combinational). Outputs held at 0 while sweeping.
  // -------------------------------------------------------------------------
  always_comb begin
    dataA = '0;
    busyA = 1'b0;
    if (state_q == S_READY && readAddress1 != ZERO_IDX) begin
      dataA = mem[readAddress1];
      busyA = busy_q[readAddress1];
`ifdef REGISTER_FILE_BYPASS_EN
      if (wr_fire && writeAddress == readAddress1) begin
        dataA = writeData;
        busyA = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    dataB = '0;
    busyB = 1'b0;
    if (state_q == S_READY && readAddress2 != ZERO_IDX) begin
      dataB = mem[readAddress2];
      busyB = busy_q[readAddress2];
`ifdef REGISTER_FILE_BYPASS_EN
      if (wr_fire && writeAddress == readAddress2) begin
        dataB = writeData;
        busyB = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// ---------------------------------------------------------------------------
// tb_register_file_sb
//   Directed testbench for register_file_sb (DATA_W=32, DEPTH=32,
//   ZERO_REG=31). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_register_file_sb;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clock;
  logic              reset;
  logic              clear;
  logic              writeRegister;
  logic [ADDR_W-1:0] writeAddress;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] readAddress1;
  logic [ADDR_W-1:0] readAddress2;
  logic              reserveValid;
  logic [ADDR_W-1:0] reserveAddress;
  logic [DATA_W-1:0] dataA;
  logic [DATA_W-1:0] dataB;
  logic              busyA;
  logic              busyB;
  logic              ready;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc;

  register_file_sb #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ZERO_REG(31)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .clear         (clear),
    .writeRegister (writeRegister),
    .writeAddress  (writeAddress),
    .writeData     (writeData),
    .readAddress1  (readAddress1),
    .readAddress2  (readAddress2),
    .reserveValid  (reserveValid),
    .reserveAddress(reserveAddress),
    .dataA         (dataA),
    .dataB         (dataB),
    .busyA         (busyA),
    .busyB         (busyB),
    .ready         (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // one clock edge, then settle away from the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    writeRegister = 1'b1;
    writeAddress  = a;
    writeData     = d;
    tick();
    writeRegister = 1'b0;
  endtask

  task automatic reserve_reg(input logic [ADDR_W-1:0] a);
    reserveValid   = 1'b1;
    reserveAddress = a;
    tick();
    reserveValid   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      readAddress1 = ADDR_W'(i);
      readAddress2 = ADDR_W'(DEPTH - 1 - i);
      #1;
      check({tag, "_dataA"}, dataA, 32'h0);
      check({tag, "_busyA"}, {31'b0, busyA}, 32'h0);
      check({tag, "_dataB"}, dataB, 32'h0);
      check({tag, "_busyB"}, {31'b0, busyB}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b0;
    clear          = 1'b0;
    writeRegister  = 1'b0;
    writeAddress   = '0;
    writeData      = '0;
    readAddress1   = 5'd3;
    readAddress2   = 5'd4;
    reserveValid   = 1'b0;
    reserveAddress = '0;

    // reset state
    #1;
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_dataA", dataA, 32'h0);
    check("rst_busyB", {31'b0, busyB}, 32'h0);

    // release reset; ready must rise exactly 32 edges later
    tick();
    tick();
    reset = 1'b1;
    wait_ready(n_cyc);
    check("sweep_len_reset", n_cyc, 32);
    check_all_zero("post_reset");

    // basic write / read
    write_reg(5'd5, 32'hDEADBEEF);
    readAddress1 = 5'd5;
    #1;
    check("wr5_dataA", dataA, 32'hDEADBEEF);
    check("wr5_busyA", {31'b0, busyA}, 32'h0);

    // hardwired zero register
    write_reg(5'd31, 32'h12345678);
    readAddress1 = 5'd31;
    readAddress2 = 5'd31;
    #1;
    check("zero_dataA", dataA, 32'h0);
    check("zero_dataB", dataB, 32'h0);
    reserve_reg(5'd31);
    check("zero_busyB", {31'b0, busyB}, 32'h0);

    // reserve then retire reg 7
    reserve_reg(5'd7);
    readAddress2 = 5'd7;
    #1;
    check("rsv7_busyB", {31'b0, busyB}, 32'h1);
    write_reg(5'd7, 32'hA5A5A5A5);
    check("ret7_busyB", {31'b0, busyB}, 32'h0);
    check("ret7_dataB", dataB, 32'hA5A5A5A5);

    // same-cycle reserve and write: reserve wins, data still written
    writeRegister  = 1'b1;
    writeAddress   = 5'd9;
    writeData      = 32'h11112222;
    reserveValid   = 1'b1;
    reserveAddress = 5'd9;
    tick();
    writeRegister  = 1'b0;
    reserveValid   = 1'b0;
    readAddress1   = 5'd9;
    #1;
    check("wr_rsv9_busyA", {31'b0, busyA}, 32'h1);
    check("wr_rsv9_dataA", dataA, 32'h11112222);
    reserve_reg(5'd9);
    check("rersv9_busyA", {31'b0, busyA}, 32'h1);

    // bypass behaviour on reg 3 (currently 0, made busy first)
    reserve_reg(5'd3);
    readAddress2  = 5'd3;
    writeRegister = 1'b1;
    writeAddress  = 5'd3;
    writeData     = 32'h00000055;
    #1;
`ifdef REGISTER_FILE_BYPASS_EN
    check("byp3_dataB_same", dataB, 32'h00000055);
    check("byp3_busyB_same", {31'b0, busyB}, 32'h0);
`else
    check("nobyp3_dataB_same", dataB, 32'h0);
    check("nobyp3_busyB_same", {31'b0, busyB}, 32'h1);
`endif
    tick();
    writeRegister = 1'b0;
    check("wr3_dataB_next", dataB, 32'h00000055);
    check("wr3_busyB_next", {31'b0, busyB}, 32'h0);

    // fill regs 0..30, reserve reg 2, then clear
    for (int i = 0; i < 31; i++) begin
      write_reg(ADDR_W'(i), 32'h10000000 + 32'(i));
    end
    reserve_reg(5'd2);
    readAddress1 = 5'd20;
    readAddress2 = 5'd2;
    #1;
    check("fill20_dataA", dataA, 32'h10000014);
    check("rsv2_busyB", {31'b0, busyB}, 32'h1);

    // clear with a competing write and reserve on the same edge
    clear          = 1'b1;
    writeRegister  = 1'b1;
    writeAddress   = 5'd4;
    writeData      = 32'hFFFF0000;
    reserveValid   = 1'b1;
    reserveAddress = 5'd6;
    tick();
    clear          = 1'b0;
    writeRegister  = 1'b0;
    reserveValid   = 1'b0;
    check("clr_ready", {31'b0, ready}, 32'h0);
    check("clr_forced_dataA", dataA, 32'h0);
    check("clr_forced_busyB", {31'b0, busyB}, 32'h0);

    // sweep length after clear; a write to reg 0 after it was swept is lost
    n_cyc = 0;
    while (!ready && n_cyc < 100) begin
      if (n_cyc == 3) begin
        writeRegister = 1'b1;
        writeAddress  = 5'd0;
        writeData     = 32'hCAFEF00D;
      end else begin
        writeRegister = 1'b0;
      end
      tick();
      n_cyc++;
    end
    writeRegister = 1'b0;
    check("sweep_len_clear", n_cyc, 32);
    check_all_zero("post_clear");

    // reset asserted mid-sweep (counter = 10) restarts the sweep
    write_reg(5'd12, 32'h0BADF00D);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    check("mid_sweep_ready", {31'b0, ready}, 32'h0);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, ready}, 32'h0);
    tick();
    reset = 1'b1;
    wait_ready(n_cyc);
    check("sweep_len_rerst", n_cyc, 32);
    check_all_zero("post_rerst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
